flit_splitter_var: RTL and testbench

Parametrised packet-to-flit serializer for a node's network interface. It sits between the memory controller and the NoC router port, in the slot the fixed 64-bit splitter occupies today. Packet width, flit payload width and queue depth are parameters. New relative to the fixed splitter: variable-length packets, optional hardware packet-ID allocation, and back-to-back packet streaming with no idle cycle between packets.

---
 rtl/flit_splitter_var.sv | 177 +++++++++++++++++
 tb/tb_flit_splitter_var.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_splitter_var.sv
// flit_splitter_var: queues whole packets in a small FIFO and serializes
// each one into header/body/tail flits for a NoC router port. Packet length
// is per-packet (clamped to the flit capacity), the packet ID comes either
// from the input or from an internal counter, and consecutive packets
// stream without an idle cycle between a TAIL and the next HEAD.
//
// Handshakes: an input packet transfers on a rising edge where
// ce && valid_in && splitter_ready; an output flit transfers on a rising
// edge where ce && valid_out && network_ready. A presented flit stays
// bit-stable until it transfers, and splitter_ready never depends on
// same-cycle activity on the output side.
module flit_splitter_var #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_WIDTH    = 64,
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int QUEUE_DEPTH     = 2,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int AUTO_ID         = 0,
  localparam int NW        = $clog2(NODE_COUNT),
  localparam int MAX_FLITS = PACKET_WIDTH / FLIT_DATA_WIDTH,
  localparam int LW        = $clog2(MAX_FLITS + 1),
  localparam int FW        = 1 + 2 * NW + FLIT_DATA_WIDTH + 3 + PACKET_ID_WIDTH + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [PACKET_WIDTH-1:0]    packet_in,
  input  logic [2:0]                 instr_in,
  input  logic [NW-1:0]              node_dest,
  input  logic [LW-1:0]              packet_len,
  input  logic [PACKET_ID_WIDTH-1:0] packet_id,
  input  logic                       valid_in,
  output logic                       splitter_ready,
  output logic [PACKET_ID_WIDTH-1:0] assigned_id,
  input  logic                       network_ready,
  output logic [FW-1:0]              output_data,
  output logic                       valid_out,
  output logic [0:0]                 stateDbg
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Packet FIFO storage, one array per field.
  logic [PACKET_WIDTH-1:0]    qPayload [QUEUE_DEPTH];
  logic [2:0]                 qInstr   [QUEUE_DEPTH];
  logic [NW-1:0]              qDest    [QUEUE_DEPTH];
  logic [LW-1:0]              qLen     [QUEUE_DEPTH];
  logic [PACKET_ID_WIDTH-1:0] qId      [QUEUE_DEPTH];
  logic [PW-1:0]              wrPtr;
  logic [PW-1:0]              rdPtr;
  logic [CW-1:0]              count;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;

  // Serializer registers for the packet currently on the wire.
  logic [0:0]                 state;
  logic [LW-1:0]              flitIdx;
  logic [LW-1:0]              curLen;
  logic [PACKET_WIDTH-1:0]    shiftReg;
  logic [2:0]                 curInstr;
  logic [NW-1:0]              curDest;
  logic [PACKET_ID_WIDTH-1:0] curId;

  logic [PACKET_ID_WIDTH-1:0] idCtr;
  logic [LW-1:0]              lenClamped;
  logic                       lastFlit;
  logic                       flitTaken;
  logic [1:0]                 flitType;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A length of zero, or one beyond capacity, means a full-size packet.
  always_comb begin
    lenClamped = packet_len;
    if (packet_len == '0 || packet_len > LW'(MAX_FLITS)) lenClamped = LW'(MAX_FLITS);
  end

  assign full           = (count == CW'(QUEUE_DEPTH));
  assign empty          = (count == '0);
  assign splitter_ready = !full;
  assign assigned_id    = (AUTO_ID != 0) ? idCtr : packet_id;
  assign push           = ce && valid_in && !full;
  assign lastFlit       = (flitIdx == curLen - LW'(1));
  assign flitTaken      = ce && (state == SEND) && network_ready;
  // Pop when idle, or exactly when the tail leaves so the next head follows
  // on the very next cycle.
  assign pop            = ce && !empty && ((state == IDLE) || (flitTaken && lastFlit));

  // Capture accepted packet fields into the FIFO slot at the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      qPayload[wrPtr] <= packet_in;
      qInstr[wrPtr]   <= instr_in;
      qDest[wrPtr]    <= node_dest;
      qLen[wrPtr]     <= lenClamped;
      qId[wrPtr]      <= assigned_id;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Packet ID counter, advancing once per accepted packet and wrapping.
  always_ff @(posedge clk) begin
    if (rst)       idCtr <= '0;
    else if (push) idCtr <= idCtr + PACKET_ID_WIDTH'(1);
  end

  // Serializer FSM: load on pop, shift out one chunk per accepted flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flitIdx  <= '0;
      curLen   <= '0;
      shiftReg <= '0;
      curInstr <= '0;
      curDest  <= '0;
      curId    <= '0;
    end else if (pop) begin
      state    <= SEND;
      flitIdx  <= '0;
      curLen   <= qLen[rdPtr];
      shiftReg <= qPayload[rdPtr];
      curInstr <= qInstr[rdPtr];
      curDest  <= qDest[rdPtr];
      curId    <= qId[rdPtr];
    end else if (flitTaken) begin
      if (lastFlit) begin
        state   <= IDLE;
        flitIdx <= '0;
      end else begin
        flitIdx  <= flitIdx + LW'(1);
        shiftReg <= shiftReg >> FLIT_DATA_WIDTH;
      end
    end
  end

  // Flit type from position within the packet.
  always_comb begin
    flitType = 2'b10;
    if (curLen == LW'(1))   flitType = 2'b00;
    else if (flitIdx == '0) flitType = 2'b01;
    else if (lastFlit)      flitType = 2'b11;
  end

  // Flit assembly; the bus is all zeros whenever nothing is being sent.
  always_comb begin
    output_data = '0;
    if (state == SEND)
      output_data = {1'b1, curDest, NW'(NODE_ID), shiftReg[FLIT_DATA_WIDTH-1:0],
                     curInstr, curId, flitType};
  end

  assign valid_out = output_data[FW-1];
  assign stateDbg  = state;

endmodule

// File: tb/tb_flit_splitter_var.sv
// Bench for flit_splitter_var: directed scenarios plus a randomized stream
// scored against a packet-level model (each accepted packet expands to its
// list of expected flits).
`timescale 1ns/1ps
module tb_flit_splitter_var;

  localparam int NW      = 4;
  localparam int PW      = 64;
  localparam int FDW     = 16;
  localparam int PIDW    = 5;
  localparam int LW      = 3;
  localparam int FW      = 35;
  localparam int NODE_ID = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            ce, valid_in, network_ready, splitter_ready, valid_out;
  logic [PW-1:0]   packet_in;
  logic [2:0]      instr_in;
  logic [NW-1:0]   node_dest;
  logic [LW-1:0]   packet_len;
  logic [PIDW-1:0] packet_id, assigned_id;
  logic [FW-1:0]   output_data;
  logic [0:0]      state_dbg;

  logic            a_ce, a_valid_in, a_network_ready, a_splitter_ready, a_valid_out;
  logic [PW-1:0]   a_packet_in;
  logic [2:0]      a_instr_in;
  logic [NW-1:0]   a_node_dest;
  logic [LW-1:0]   a_packet_len;
  logic [PIDW-1:0] a_packet_id, a_assigned_id;
  logic [FW-1:0]   a_output_data;
  logic [0:0]      a_state_dbg;

  flit_splitter_var dut (
    .clk(clk), .rst(rst), .ce(ce), .packet_in(packet_in), .instr_in(instr_in),
    .node_dest(node_dest), .packet_len(packet_len), .packet_id(packet_id),
    .valid_in(valid_in), .splitter_ready(splitter_ready), .assigned_id(assigned_id),
    .network_ready(network_ready), .output_data(output_data), .valid_out(valid_out),
    .stateDbg(state_dbg)
  );

  flit_splitter_var #(.AUTO_ID(1)) dut_auto (
    .clk(clk), .rst(rst), .ce(a_ce), .packet_in(a_packet_in), .instr_in(a_instr_in),
    .node_dest(a_node_dest), .packet_len(a_packet_len), .packet_id(a_packet_id),
    .valid_in(a_valid_in), .splitter_ready(a_splitter_ready), .assigned_id(a_assigned_id),
    .network_ready(a_network_ready), .output_data(a_output_data), .valid_out(a_valid_out),
    .stateDbg(a_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] obs_q[$];

  function automatic int eff_len(input logic [LW-1:0] l);
    return (l == 0 || l > 4) ? 4 : int'(l);
  endfunction

  function automatic logic [FW-1:0] model_flit(input logic [PW-1:0] pay, input logic [2:0] ins,
                                               input logic [NW-1:0] dst, input logic [PIDW-1:0] id,
                                               input int k, input int n);
    logic [1:0] t;
    if (n == 1)          t = 2'b00;
    else if (k == 0)     t = 2'b01;
    else if (k == n - 1) t = 2'b11;
    else                 t = 2'b10;
    return {1'b1, dst, NW'(NODE_ID), pay[k*FDW +: FDW], ins, id, t};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: records the flit handed to the network and, for an accepted
  // packet, the flits the model says it must produce.
  task automatic step();
    logic acc, take, was_rst;
    logic [FW-1:0] flit;
    int n;
    acc     = ce && valid_in && splitter_ready;
    take    = ce && valid_out && network_ready;
    was_rst = rst;
    flit    = output_data;
    n       = eff_len(packet_len);
    @(posedge clk); #1;
    if (was_rst !== 1'b1) begin
      if (take === 1'b1) obs_q.push_back(flit);
      if (acc === 1'b1)
        for (int k = 0; k < n; k++)
          exp_q.push_back(model_flit(packet_in, instr_in, node_dest, packet_id, k, n));
    end
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int c = 0;
    while (obs_q.size() < exp_q.size() && c < budget) begin
      step();
      c++;
    end
    timed_out = (obs_q.size() < exp_q.size());
  endtask

  task automatic offer(input logic [PW-1:0] p, input logic [LW-1:0] l, input logic [PIDW-1:0] id);
    packet_in  = p;
    packet_len = l;
    packet_id  = id;
    instr_in   = 3'($urandom_range(0, 7));
    node_dest  = NW'($urandom_range(0, 15));
    valid_in   = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; valid_in = 1'b0; network_ready = 1'b0;
    packet_in = '0; instr_in = '0; node_dest = '0; packet_len = '0; packet_id = 5'd19;
    a_ce = 1'b1; a_valid_in = 1'b0; a_network_ready = 1'b1; a_packet_in = '0;
    a_instr_in = '0; a_node_dest = '0; a_packet_len = 3'd1; a_packet_id = 5'd7;
    repeat (2) step();
    total++; if (output_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", output_data); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (splitter_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", splitter_ready); end
    total++; if (state_dbg !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    total++; if (assigned_id !== 5'd19) begin bad++; $display("FAIL reset_passid: got %0d want 19", assigned_id); end
    total++; if (a_assigned_id !== 5'd0) begin bad++; $display("FAIL reset_autoid: got %0d want 0", a_assigned_id); end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_full();
    logic [15:0] pay_c[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [1:0]  typ_c[4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    bit to;
    network_ready = 1'b1;
    offer(64'h4444_3333_2222_1111, 3'd0, 5'd12);
    step();
    valid_in = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL full_early: valid %b want 0", valid_out); end
    step();
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL full_latency: valid %b want 1", valid_out); end
    drain(20, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL full_drain: timeout, got %0d flits want %0d", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL full_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i][10 +: 16] !== pay_c[i]) begin bad++; $display("FAIL full_payload%0d: got %h want %h", i, obs_q[i][10 +: 16], pay_c[i]); end
      total++; if (obs_q[i][1:0] !== typ_c[i]) begin bad++; $display("FAIL full_type%0d: got %b want %b", i, obs_q[i][1:0], typ_c[i]); end
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len();
    logic [PW-1:0] p;
    logic [FW-1:0] got, want;
    bit to;
    network_ready = 1'b1;
    p = {$urandom, $urandom};
    offer(p, 3'd1, 5'd4);
    step();
    valid_in = 1'b0;
    drain(20, to);
    total++; if (to !== 1'b0 || obs_q.size() != 1) begin bad++; $display("FAIL len1_count: got %0d flits want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++; if (obs_q[0][1:0] !== 2'b00) begin bad++; $display("FAIL len1_type: got %b want 00", obs_q[0][1:0]); end
      total++; if (obs_q[0][10 +: 16] !== p[15:0]) begin bad++; $display("FAIL len1_payload: got %h want %h", obs_q[0][10 +: 16], p[15:0]); end
    end
    exp_q.delete(); obs_q.delete();
    offer({$urandom, $urandom}, 3'd7, 5'd30);
    step();
    valid_in = 1'b0;
    drain(20, to);
    total++; if (to !== 1'b0 || obs_q.size() != 4) begin bad++; $display("FAIL len7_count: got %0d flits want 4", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL len7_flit: extra flit %h, none expected", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL len7_flit: got %h want %h", got, want); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic v[5];
    logic v_c[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] typ_c[4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    network_ready = 1'b1;
    offer({$urandom, $urandom}, 3'd2, 5'd1);
    step();
    offer({$urandom, $urandom}, 3'd2, 5'd2);
    step();
    valid_in = 1'b0;
    v[0] = valid_out;
    for (int i = 1; i < 5; i++) begin
      step();
      v[i] = valid_out;
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (v[i] !== v_c[i]) begin bad++; $display("FAIL b2b_valid%0d: got %b want %b", i, v[i], v_c[i]); end
    end
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i][1:0] !== typ_c[i]) begin bad++; $display("FAIL b2b_type%0d: got %b want %b", i, obs_q[i][1:0], typ_c[i]); end
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] held, got, want;
    logic rdy_c[3] = '{1'b0, 1'b0, 1'b1};
    bit to;
    network_ready = 1'b1;
    offer({$urandom, $urandom}, 3'd4, 5'd3);
    step();
    valid_in = 1'b0;
    step();
    step();
    network_ready = 1'b0;
    held = output_data;
    total++; if (held[1:0] !== 2'b10) begin bad++; $display("FAIL bp_body: type %b want 10", held[1:0]); end
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      offer({$urandom, $urandom}, 3'd2, 5'd7);
      else if (i == 1) offer({$urandom, $urandom}, 3'd3, 5'd9);
      else             offer({$urandom, $urandom}, 3'd1, 5'd21);
      step();
      total++; if (output_data !== held) begin bad++; $display("FAIL bp_hold%0d: got %h want %h", i, output_data, held); end
      total++; if (splitter_ready !== (i == 0)) begin bad++; $display("FAIL bp_ready%0d: got %b want %b", i, splitter_ready, i == 0); end
    end
    valid_in = 1'b0;
    network_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (splitter_ready !== rdy_c[i]) begin bad++; $display("FAIL bp_release%0d: ready %b want %b", i, splitter_ready, rdy_c[i]); end
    end
    drain(40, to);
    total++; if (to !== 1'b0 || obs_q.size() != 9) begin bad++; $display("FAIL bp_count: got %0d flits want 9", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL bp_flit: extra flit %h, none expected", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL bp_flit: got %h want %h", got, want); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [FW-1:0] prev, got, want;
    logic prev_ce;
    bit to;
    repeat (400) begin
      ce            = ($urandom_range(0, 9) < 8);
      network_ready = ($urandom_range(0, 9) < 7);
      valid_in      = 1'($urandom_range(0, 1));
      packet_in     = {$urandom, $urandom};
      instr_in      = 3'($urandom_range(0, 7));
      node_dest     = NW'($urandom_range(0, 15));
      packet_len    = LW'($urandom_range(0, 7));
      packet_id     = PIDW'($urandom_range(0, 31));
      prev = output_data;
      prev_ce = ce;
      step();
      if (!prev_ce) begin
        total++; if (output_data !== prev) begin bad++; $display("FAIL rand_ce_hold: got %h want %h", output_data, prev); end
      end
    end
    ce = 1'b1; valid_in = 1'b0; network_ready = 1'b1;
    drain(200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rand_drain: got %0d flits want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL rand_flit: extra flit %h, none expected", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL rand_flit: got %h want %h", got, want); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_auto_id();
    logic [PIDW-1:0] ids[$];
    logic acc, take;
    logic [FW-1:0] fl;
    int acc_n = 0;
    int cyc = 0;
    a_ce = 1'b1; a_network_ready = 1'b1; a_packet_len = 3'd1;
    while ((acc_n < 33 || ids.size() < 33) && cyc < 300) begin
      a_valid_in  = (acc_n < 33);
      a_packet_id = PIDW'($urandom_range(0, 31));
      a_packet_in = {$urandom, $urandom};
      acc  = a_valid_in && a_splitter_ready;
      take = a_valid_out && a_network_ready;
      fl   = a_output_data;
      if (acc === 1'b1) begin
        total++; if (a_assigned_id !== PIDW'(acc_n % 32)) begin bad++; $display("FAIL auto_assigned%0d: got %0d want %0d", acc_n, a_assigned_id, acc_n % 32); end
      end
      @(posedge clk); #1;
      if (acc === 1'b1) acc_n++;
      if (take === 1'b1) ids.push_back(fl[2 +: PIDW]);
      cyc++;
    end
    a_valid_in = 1'b0;
    total++; if (ids.size() != 33) begin bad++; $display("FAIL auto_count: got %0d flits want 33", ids.size()); end
    for (int i = 0; i < ids.size(); i++) begin
      total++; if (ids[i] !== PIDW'(i % 32)) begin bad++; $display("FAIL auto_id%0d: got %0d want %0d", i, ids[i], i % 32); end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] got, want;
    bit to;
    network_ready = 1'b1;
    offer({$urandom, $urandom}, 3'd4, 5'd5);
    step();
    offer({$urandom, $urandom}, 3'd4, 5'd6);
    step();
    offer({$urandom, $urandom}, 3'd2, 5'd8);
    step();
    valid_in = 1'b0;
    total++; if (output_data[1:0] !== 2'b10 || valid_out !== 1'b1) begin bad++; $display("FAIL rstmid_body: type %b valid %b want 10/1", output_data[1:0], valid_out); end
    total++; if (splitter_ready !== 1'b0) begin bad++; $display("FAIL rstmid_full: ready %b want 0", splitter_ready); end
    network_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (output_data !== '0) begin bad++; $display("FAIL rstmid_data: got %h want 0", output_data); end
    total++; if (splitter_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", splitter_ready); end
    total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL rstmid_head: %0d flits before reset, want 1 matching head", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
    network_ready = 1'b1;
    repeat (3) step();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_flushed: valid %b want 0", valid_out); end
    offer({$urandom, $urandom}, 3'd3, 5'd11);
    step();
    valid_in = 1'b0;
    drain(20, to);
    total++; if (to !== 1'b0 || obs_q.size() != 3) begin bad++; $display("FAIL rstmid_count: got %0d flits want 3", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++; if (obs_q[0][1:0] !== 2'b01) begin bad++; $display("FAIL rstmid_newhead: type %b want 01", obs_q[0][1:0]); end
    end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL rstmid_flit: extra flit %h, none expected", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL rstmid_flit: got %h want %h", got, want); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_full();
    test_len();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_auto_id();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
